// File: rtl/lsu_align_splitter.sv
// ---------------------------------------------------------------------------
// lsu_align_splitter
//
// Memory-stage front end sitting between the EX/MEM pipeline register and the
// data memory. Naturally aligned loads/stores are forwarded unchanged in the
// same cycle. Misaligned halfword/word accesses, plus every LHU and SH, are
// broken into sequential byte accesses (LBU for loads, SB for stores). Load
// bytes are reassembled little-endian and sign/zero extended. The pipeline is
// stalled until the final byte is issued.
//
// Downstream memory only ever sees Funct3 000, 001 (aligned LH), 010 and 100.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   When defined, the misalign_exc output is added. An access that would
//   otherwise split because it is misaligned raises misalign_exc for one cycle
//   and issues no memory access. Aligned LHU/SH still split into two bytes.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   MemRead, MemWrite   request from EX/MEM (both high = load)
//   addr, wd, Funct3    byte address, store data, access size/sign
//   stall               holds IF/ID/EX/MEM while high
//   load_data/load_done extended load result and its valid strobe
//   dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3   data memory request
//   dm_rd               data memory read data, valid in the request cycle
//   misalign_exc        misalignment trap strobe (macro builds only)
// ---------------------------------------------------------------------------
module lsu_align_splitter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic                  stall,
    output logic [DATA_W-1:0]     load_data,
    output logic                  load_done,
    output logic                  dm_MemRead,
    output logic                  dm_MemWrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_Funct3,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign_exc,
`endif
    input  logic [DATA_W-1:0]     dm_rd
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]            state;
    logic [1:0]            count;
    logic [7:0]            byte0, byte1, byte2;
    logic                  lat_load;
    logic [2:0]            lat_f3;
    logic [DM_ADDRESS-1:0] lat_a;
    logic [DATA_W-1:0]     lat_wd;

    logic [DM_ADDRESS-1:0] a;
    logic                  is_load, is_store;
    logic                  pass, split, start_split;
    logic [1:0]            last_k;
    logic                  last_byte;
    logic [7:0]            wd_lane;
    logic                  unused_addr_hi;

    assign a              = addr[DM_ADDRESS-1:0];
    assign unused_addr_hi = ^addr[DATA_W-1:DM_ADDRESS];
    assign is_load        = MemRead;
    assign is_store       = MemWrite & ~MemRead;

    // Decide whether an incoming request can go straight through or must be
    // broken into bytes. Unsupported Funct3 codes fall out as neither.
    always_comb begin
        pass  = 1'b0;
        split = 1'b0;
        if (is_load) begin
            case (Funct3)
                3'b000, 3'b100: pass = 1'b1;
                3'b001:         if (a[0]) split = 1'b1; else pass = 1'b1;
                3'b010:         if (a[1:0] != 2'b00) split = 1'b1; else pass = 1'b1;
                3'b101:         split = 1'b1;
                default:        ;
            endcase
        end else if (is_store) begin
            case (Funct3)
                3'b000:  pass = 1'b1;
                3'b001:  split = 1'b1;
                3'b010:  if (a[1:0] != 2'b00) split = 1'b1; else pass = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Only genuinely misaligned splits trap; aligned LHU/SH keep splitting.
    logic trap_hit;
    assign trap_hit    = split & ((Funct3 == 3'b010) | a[0]);
    assign start_split = split & ~trap_hit;
`else
    assign start_split = split;
`endif

    assign last_k    = (lat_f3 == 3'b010) ? 2'd3 : 2'd1;
    assign last_byte = (count == last_k);

    // Select the store byte lane matching the byte currently being issued.
    always_comb begin
        case (count)
            2'd0:    wd_lane = lat_wd[7:0];
            2'd1:    wd_lane = lat_wd[15:8];
            2'd2:    wd_lane = lat_wd[23:16];
            default: wd_lane = lat_wd[31:24];
        endcase
    end

    // Output decode. Everything is forced low while reset is held so an
    // aborted split cannot issue another byte or report a result.
    always_comb begin
        stall       = 1'b0;
        load_data   = '0;
        load_done   = 1'b0;
        dm_MemRead  = 1'b0;
        dm_MemWrite = 1'b0;
        dm_a        = '0;
        dm_wd       = '0;
        dm_Funct3   = 3'b000;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_exc = 1'b0;
`endif
        if (reset_n) begin
            if (state == IDLE) begin
                if (pass) begin
                    dm_MemRead  = is_load;
                    dm_MemWrite = is_store;
                    dm_a        = a;
                    dm_wd       = wd;
                    dm_Funct3   = Funct3;
                    load_done   = is_load;
                    load_data   = is_load ? dm_rd : '0;
                end else if (start_split) begin
                    stall       = 1'b1;
                    dm_MemRead  = is_load;
                    dm_MemWrite = is_store;
                    dm_a        = a;
                    dm_wd       = {24'b0, wd[7:0]};
                    dm_Funct3   = is_load ? 3'b100 : 3'b000;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_exc = trap_hit;
`endif
            end else begin
                stall       = ~last_byte;
                dm_MemRead  = lat_load;
                dm_MemWrite = ~lat_load;
                dm_a        = lat_a + {{(DM_ADDRESS-2){1'b0}}, count};
                dm_wd       = {24'b0, wd_lane};
                dm_Funct3   = lat_load ? 3'b100 : 3'b000;
                if (lat_load && last_byte) begin
                    load_done = 1'b1;
                    case (lat_f3)
                        3'b001:  load_data = {{16{dm_rd[7]}}, dm_rd[7:0], byte0};
                        3'b101:  load_data = {16'b0, dm_rd[7:0], byte0};
                        default: load_data = {dm_rd[7:0], byte2, byte1, byte0};
                    endcase
                end
            end
        end
    end

    // Split sequencer: latch the request on entry, capture one read byte per
    // cycle, and fall back to IDLE once the last byte has been issued. The
    // final byte is taken live from dm_rd, so only bytes 0..2 are stored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= 2'd0;
            byte0    <= 8'd0;
            byte1    <= 8'd0;
            byte2    <= 8'd0;
            lat_load <= 1'b0;
            lat_f3   <= 3'b000;
            lat_a    <= '0;
            lat_wd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_split) begin
                        state    <= SPLIT;
                        count    <= 2'd1;
                        byte0    <= dm_rd[7:0];
                        lat_load <= is_load;
                        lat_f3   <= Funct3;
                        lat_a    <= a;
                        lat_wd   <= wd;
                    end
                end
                SPLIT: begin
                    if (count == 2'd1) byte1 <= dm_rd[7:0];
                    if (count == 2'd2) byte2 <= dm_rd[7:0];
                    if (last_byte) begin
                        state <= IDLE;
                        count <= 2'd0;
                    end else begin
                        count <= count + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align_splitter.sv
// ---------------------------------------------------------------------------
// tb_lsu_align_splitter
//
// Directed bench for lsu_align_splitter with a byte-addressed behavioural
// data memory (512 bytes, little-endian, same-cycle read). Memory contents
// are preloaded through a backdoor write port so expected values are known.
// ---------------------------------------------------------------------------
module tb_lsu_align_splitter;

    logic        clk;
    logic        reset_n;
    logic        MemRead, MemWrite;
    logic [31:0] addr, wd;
    logic [2:0]  Funct3;
    logic        stall, load_done;
    logic [31:0] load_data;
    logic        dm_MemRead, dm_MemWrite;
    logic [8:0]  dm_a;
    logic [31:0] dm_wd, dm_rd;
    logic [2:0]  dm_Funct3;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    int check_count = 0;
    int error_count = 0;

    logic [7:0]  mem [0:511];
    logic        bd_we;
    logic [8:0]  bd_a;
    logic [7:0]  bd_d;
    logic [8:0]  a1, a2, a3;

    lsu_align_splitter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .addr(addr),
        .wd(wd),
        .Funct3(Funct3),
        .stall(stall),
        .load_data(load_data),
        .load_done(load_done),
        .dm_MemRead(dm_MemRead),
        .dm_MemWrite(dm_MemWrite),
        .dm_a(dm_a),
        .dm_wd(dm_wd),
        .dm_Funct3(dm_Funct3),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_exc(misalign_exc),
`endif
        .dm_rd(dm_rd)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a1 = dm_a + 9'd1;
    assign a2 = dm_a + 9'd2;
    assign a3 = dm_a + 9'd3;

    // Behavioural data memory read port: same-cycle, extended per Funct3.
    always_comb begin
        case (dm_Funct3)
            3'b000:  dm_rd = {{24{mem[dm_a][7]}}, mem[dm_a]};
            3'b100:  dm_rd = {24'b0, mem[dm_a]};
            3'b001:  dm_rd = {{16{mem[a1][7]}}, mem[a1], mem[dm_a]};
            3'b101:  dm_rd = {16'b0, mem[a1], mem[dm_a]};
            3'b010:  dm_rd = {mem[a3], mem[a2], mem[a1], mem[dm_a]};
            default: dm_rd = 32'b0;
        endcase
    end

    // Memory write port, shared between the bench backdoor and the DUT.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_a] <= bd_d;
        end else if (dm_MemWrite) begin
            case (dm_Funct3)
                3'b000: mem[dm_a] <= dm_wd[7:0];
                3'b001: begin
                    mem[dm_a] <= dm_wd[7:0];
                    mem[a1]   <= dm_wd[15:8];
                end
                3'b010: begin
                    mem[dm_a] <= dm_wd[7:0];
                    mem[a1]   <= dm_wd[15:8];
                    mem[a2]   <= dm_wd[23:16];
                    mem[a3]   <= dm_wd[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a request and let the combinational outputs settle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d);
        MemRead  = rd;
        MemWrite = wr;
        Funct3   = f3;
        addr     = a;
        wd       = d;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [8:0] a, input logic [7:0] d);
        bd_a  = a;
        bd_d  = d;
        bd_we = 1'b1;
        nextCycle();
        bd_we = 1'b0;
    endtask

    // Walk a split load issued in the current cycle; inputs are scrambled on
    // later cycles to show only latched values are used.
    task automatic runSplitLoad(input string tag, input logic [31:0] a, input int n,
                                input logic [31:0] exp);
        for (int k = 0; k < n; k++) begin
            checkOutput({tag, "_dm_a"}, {23'b0, dm_a}, (a + k) & 32'h1FF);
            checkOutput({tag, "_f3"}, {29'b0, dm_Funct3}, 32'd4);
            checkOutput({tag, "_rd"}, {31'b0, dm_MemRead}, 32'd1);
            checkOutput({tag, "_stall"}, {31'b0, stall}, (k < n - 1) ? 32'd1 : 32'd0);
            checkOutput({tag, "_done"}, {31'b0, load_done}, (k == n - 1) ? 32'd1 : 32'd0);
            if (k == n - 1) checkOutput({tag, "_data"}, load_data, exp);
            nextCycle();
            applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_01AA, 32'hFFFF_FFFF);
        end
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput({tag, "_idle_stall"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        bd_we = 1'b0;
        bd_a  = '0;
        bd_d  = '0;
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hFFFF_FFFF);
        $display("[TB] reset checks");
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_done", {31'b0, load_done}, 32'd0);
        checkOutput("rst_data", load_data, 32'd0);
        checkOutput("rst_dm_rd", {31'b0, dm_MemRead}, 32'd0);
        checkOutput("rst_dm_wr", {31'b0, dm_MemWrite}, 32'd0);
        checkOutput("rst_dm_a", {23'b0, dm_a}, 32'd0);
        checkOutput("rst_dm_wd", dm_wd, 32'd0);
        checkOutput("rst_dm_f3", {29'b0, dm_Funct3}, 32'd0);
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Aligned LW pass-through.
        poke(9'h010, 8'h78); poke(9'h011, 8'h56); poke(9'h012, 8'h34); poke(9'h013, 8'h12);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        checkOutput("lw_al_f3", {29'b0, dm_Funct3}, 32'd2);
        checkOutput("lw_al_a", {23'b0, dm_a}, 32'h10);
        checkOutput("lw_al_data", load_data, 32'h1234_5678);
        checkOutput("lw_al_done", {31'b0, load_done}, 32'd1);
        checkOutput("lw_al_stall", {31'b0, stall}, 32'd0);
        nextCycle();

        // Both MemRead and MemWrite high behaves as a load.
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D);
        checkOutput("rdwr_wr", {31'b0, dm_MemWrite}, 32'd0);
        checkOutput("rdwr_data", load_data, 32'h1234_5678);
        nextCycle();

        // Unsupported Funct3 issues nothing.
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0);
        checkOutput("f3_011_rd", {31'b0, dm_MemRead}, 32'd0);
        checkOutput("f3_011_done", {31'b0, load_done}, 32'd0);
        checkOutput("f3_011_stall", {31'b0, stall}, 32'd0);
        nextCycle();

        // Aligned LHU always splits into two bytes; aligned LH passes.
        poke(9'h020, 8'h34); poke(9'h021, 8'hB2);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0020, 32'h0);
        runSplitLoad("lhu_al", 32'h20, 2, 32'h0000_B234);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0020, 32'h0);
        checkOutput("lh_al_f3", {29'b0, dm_Funct3}, 32'd1);
        checkOutput("lh_al_data", load_data, 32'hFFFF_B234);
        checkOutput("lh_al_stall", {31'b0, stall}, 32'd0);
        nextCycle();

        // SB pass-through.
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0005, 32'h0000_005A);
        checkOutput("sb_wr", {31'b0, dm_MemWrite}, 32'd1);
        checkOutput("sb_f3", {29'b0, dm_Funct3}, 32'd0);
        checkOutput("sb_stall", {31'b0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput("sb_mem", {24'b0, mem[9'h005]}, 32'h5A);

`ifndef LSU_MISALIGN_TRAP_EN
        // Misaligned LW.
        poke(9'h011, 8'hEF); poke(9'h012, 8'hBE); poke(9'h013, 8'hAD); poke(9'h014, 8'hDE);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0011, 32'h0);
        runSplitLoad("lw_mis", 32'h11, 4, 32'hDEAD_BEEF);

        // Misaligned LH / LHU.
        poke(9'h023, 8'h80); poke(9'h024, 8'hFF);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0023, 32'h0);
        runSplitLoad("lh_mis", 32'h23, 2, 32'hFFFF_FF80);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0023, 32'h0);
        runSplitLoad("lhu_mis", 32'h23, 2, 32'h0000_FF80);

        // Misaligned SW across the top of the address space.
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_01FE, 32'hA1B2_C3D4);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] lanes;
            lanes = 32'hA1B2_C3D4;
            checkOutput("sw_wrap_a", {23'b0, dm_a}, (32'h1FE + k) & 32'h1FF);
            checkOutput("sw_wrap_wd", {24'b0, dm_wd[7:0]}, (lanes >> (8 * k)) & 32'hFF);
            checkOutput("sw_wrap_f3", {29'b0, dm_Funct3}, 32'd0);
            checkOutput("sw_wrap_stall", {31'b0, stall}, (k < 3) ? 32'd1 : 32'd0);
            nextCycle();
            applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
        checkOutput("sw_wrap_rb", load_data & 32'h0000_FFFF, 32'h0000_A1B2);
        checkOutput("sw_wrap_1ff", {24'b0, mem[9'h1FF]}, 32'hC3);
        nextCycle();

        // Reset in the middle of a split store.
        poke(9'h041, 8'h00); poke(9'h042, 8'h00); poke(9'h043, 8'h00); poke(9'h044, 8'h00);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0041, 32'h1122_3344);
        checkOutput("abort_b0_wd", {24'b0, dm_wd[7:0]}, 32'h44);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput("abort_b1_a", {23'b0, dm_a}, 32'h42);
        checkOutput("abort_b1_wd", {24'b0, dm_wd[7:0]}, 32'h33);
        nextCycle();
        reset_n = 1'b0;
        #1;
        checkOutput("abort_rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("abort_rst_wr", {31'b0, dm_MemWrite}, 32'd0);
        checkOutput("abort_rst_a", {23'b0, dm_a}, 32'd0);
        checkOutput("abort_rst_wd", dm_wd, 32'd0);
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0041, 32'h0);
        checkOutput("abort_next_stall", {31'b0, stall}, 32'd0);
        checkOutput("abort_next_data", load_data, 32'h44);
        checkOutput("abort_mem42", {24'b0, mem[9'h042]}, 32'h33);
        checkOutput("abort_mem43", {24'b0, mem[9'h043]}, 32'h00);
        checkOutput("abort_mem44", {24'b0, mem[9'h044]}, 32'h00);
        nextCycle();
`else
        // Misaligned LW traps; a following LB proceeds normally.
        poke(9'h003, 8'h9C);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0);
        checkOutput("trap_exc", {31'b0, misalign_exc}, 32'd1);
        checkOutput("trap_rd", {31'b0, dm_MemRead}, 32'd0);
        checkOutput("trap_stall", {31'b0, stall}, 32'd0);
        checkOutput("trap_done", {31'b0, load_done}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'h0);
        checkOutput("trap_lb_exc", {31'b0, misalign_exc}, 32'd0);
        checkOutput("trap_lb_data", load_data, 32'hFFFF_FF9C);
        checkOutput("trap_lb_done", {31'b0, load_done}, 32'd1);
        nextCycle();
        // Misaligned SH also traps and writes nothing.
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0000_7777);
        checkOutput("trap_sh_exc", {31'b0, misalign_exc}, 32'd1);
        checkOutput("trap_sh_wr", {31'b0, dm_MemWrite}, 32'd0);
        nextCycle();
`endif

        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
